// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-access stage.
// The MEM_ALIGN_CHK_EN build option itself is consumed in mem_access_unit.
package mem_pkg;

    localparam int unsigned DW_DEFAULT      = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_e;

    // Exactly one of load/store selects a real memory access.
    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Execute-result, data-memory and writeback signals of the memory stage.
// slave = memory-stage view, master = surrounding pipeline / memory view.
interface mem_access_unit_if
    import mem_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) ();

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] st_data;
    logic          mem_rd;
    logic          mem_wr;

    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_done;
    logic [DW-1:0] dmem_rdata;

    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic          wb_err;

    modport slave (
        input  in_valid, alu_res, st_data, mem_rd, mem_wr,
        input  dmem_done, dmem_rdata, wb_ready,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_data, wb_err
    );

    modport master (
        output in_valid, alu_res, st_data, mem_rd, mem_wr,
        output dmem_done, dmem_rdata, wb_ready,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_data, wb_err
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Saturating access-cycle counter; o_expired flags the final allowed wait cycle.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != CW'(TIMEOUT))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Asserted while the count is on its way to TIMEOUT this cycle.
    assign o_expired = (r_cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: multi-cycle req/done data access with registered writeback.
// Build option MEM_ALIGN_CHK_EN rejects odd-address loads/stores with wb_err.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DW      = DW_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    mem_access_unit_if.slave bus
);

    mem_state_e    r_state;
    logic          r_req;
    logic          r_we;
    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_wb_valid;
    logic          r_wb_err;
    logic [DW-1:0] r_wb_data;

    logic w_in_ready;
    logic w_accept;
    logic w_mem_op;
    logic w_misalign;
    logic w_in_access;
    logic w_expired;

`ifdef MEM_ALIGN_CHK_EN
    assign w_misalign = bus.alu_res[0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_in_ready  = (r_state == IDLE) && (!r_wb_valid || bus.wb_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_mem_op    = is_mem_op(bus.mem_rd, bus.mem_wr);
    assign w_in_access = (r_state == ACCESS);

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_accept),
        .i_en     (w_in_access),
        .o_expired(w_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_err   <= 1'b0;
            r_wb_data  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_mem_op && !w_misalign) begin
                            r_addr     <= bus.alu_res;
                            r_wdata    <= bus.st_data;
                            r_we       <= bus.mem_wr;
                            r_req      <= 1'b1;
                            r_wb_valid <= 1'b0;
                            r_state    <= ACCESS;
                        end else begin
                            // Plain ALU op, or an illegal/misaligned access reported at once.
                            r_wb_data  <= bus.alu_res;
                            r_wb_err   <= bus.mem_rd | bus.mem_wr;
                            r_wb_valid <= 1'b1;
                        end
                    end else if (bus.wb_ready) begin
                        r_wb_valid <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (bus.dmem_done) begin
                        r_req      <= 1'b0;
                        r_wb_data  <= r_we ? r_addr : bus.dmem_rdata;
                        r_wb_err   <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_state    <= RESP;
                    end else if (w_expired) begin
                        r_req      <= 1'b0;
                        r_wb_data  <= '0;
                        r_wb_err   <= 1'b1;
                        r_wb_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (bus.wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.dmem_req   = r_req;
    assign bus.dmem_we    = r_we;
    assign bus.dmem_addr  = r_addr;
    assign bus.dmem_wdata = r_wdata;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_data    = r_wb_data;
    assign bus.wb_err     = r_wb_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against an op-level result model.
module tb_mem_access_unit;

    localparam int unsigned DW = 16;
    localparam int unsigned TO = 15;
`ifdef MEM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errs   = 0;

    mem_access_unit_if #(.DW(DW)) bus ();

    mem_access_unit #(
        .DW     (DW),
        .TIMEOUT(TO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One op end-to-end. Expected outcome is derived from the op kind only:
    // lat = cycle of dmem_req in which done is pulsed (> TO means never).
    task automatic run_op(input string tag, input logic [15:0] alu, input logic [15:0] st,
                          input bit rd, input bit wr, input int lat,
                          input logic [15:0] rdata, input int hold);
        bit            is_mem;
        bit            timeout;
        logic          exp_err;
        logic [15:0]   exp_data;
        int            exp_cycles;
        int            req_cycles;
        int            w;
        bit            ir_bad;
        bit            unstable;

        is_mem = (rd != wr) && !(ALIGN_CHK && alu[0]);
        timeout = is_mem && (lat > int'(TO));
        exp_cycles = (lat > int'(TO)) ? int'(TO) : lat;
        if (!is_mem) begin
            exp_data = alu;
            exp_err  = rd | wr;
        end else if (timeout) begin
            exp_data = 16'h0000;
            exp_err  = 1'b1;
        end else begin
            exp_data = rd ? rdata : alu;
            exp_err  = 1'b0;
        end

        bus.in_valid = 1'b0;
        bus.wb_ready = 1'b1;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk({tag, "_idle_ready"}, bus.in_ready, 1'b1);

        bus.in_valid = 1'b1;
        bus.alu_res  = alu;
        bus.st_data  = st;
        bus.mem_rd   = rd;
        bus.mem_wr   = wr;
        tick();
        bus.in_valid = 1'b0;
        bus.alu_res  = 16'($urandom);
        bus.st_data  = 16'($urandom);
        bus.wb_ready = 1'b0;

        if (is_mem) begin
            chk({tag, "_req"}, bus.dmem_req, 1'b1);
            chk({tag, "_we"}, bus.dmem_we, wr);
            chk({tag, "_addr"}, bus.dmem_addr, alu);
            chk({tag, "_wdata"}, bus.dmem_wdata, st);
            req_cycles = 0;
            ir_bad = 1'b0;
            for (int i = 1; i <= 40; i++) begin
                if (bus.dmem_req !== 1'b1) break;
                req_cycles++;
                if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b0) ir_bad = 1'b1;
                if (i == lat) begin
                    bus.dmem_done  = 1'b1;
                    bus.dmem_rdata = rdata;
                end
                tick();
                bus.dmem_done  = 1'b0;
                bus.dmem_rdata = 16'($urandom);
            end
            chk({tag, "_req_cycles"}, req_cycles, exp_cycles);
            chk({tag, "_stall"}, ir_bad, 1'b0);
        end else begin
            chk({tag, "_no_req"}, bus.dmem_req, 1'b0);
        end

        chk({tag, "_wb_valid"}, bus.wb_valid, 1'b1);
        chk({tag, "_wb_data"}, bus.wb_data, exp_data);
        chk({tag, "_wb_err"}, bus.wb_err, exp_err);

        unstable = 1'b0;
        for (int h = 0; h < hold; h++) begin
            // A stray done while not accessing must change nothing.
            if (h == 0) begin
                bus.dmem_done  = 1'b1;
                bus.dmem_rdata = 16'($urandom);
            end
            tick();
            bus.dmem_done = 1'b0;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp_data || bus.wb_err !== exp_err ||
                bus.in_ready !== 1'b0 || bus.dmem_req !== 1'b0) unstable = 1'b1;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, unstable, 1'b0);

        bus.wb_ready = 1'b1;
        #1;
        chk({tag, "_ready_on_release"}, bus.in_ready, !is_mem);
        tick();
        chk({tag, "_wb_cleared"}, bus.wb_valid, 1'b0);
        chk({tag, "_ready_after"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] s;
        bit          rd;
        bit          wr;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.alu_res    = '0;
        bus.st_data    = '0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.dmem_done  = 1'b0;
        bus.dmem_rdata = '0;
        bus.wb_ready   = 1'b1;
        tick();
        tick();
        chk("rst_req", bus.dmem_req, 1'b0);
        chk("rst_we", bus.dmem_we, 1'b0);
        chk("rst_addr", bus.dmem_addr, 16'h0000);
        chk("rst_wdata", bus.dmem_wdata, 16'h0000);
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_wb_data", bus.wb_data, 16'h0000);
        chk("rst_wb_err", bus.wb_err, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        // Back-to-back non-memory ops at one per cycle.
        bus.in_valid = 1'b1;
        bus.alu_res  = 16'h1234;
        #1;
        chk("b2b_ready0", bus.in_ready, 1'b1);
        tick();
        chk("b2b_valid0", bus.wb_valid, 1'b1);
        chk("b2b_data0", bus.wb_data, 16'h1234);
        chk("b2b_err0", bus.wb_err, 1'b0);
        chk("b2b_ready1", bus.in_ready, 1'b1);
        bus.alu_res = 16'h5678;
        tick();
        chk("b2b_valid1", bus.wb_valid, 1'b1);
        chk("b2b_data1", bus.wb_data, 16'h5678);
        bus.in_valid = 1'b0;
        tick();
        chk("b2b_drain", bus.wb_valid, 1'b0);

        run_op("load", 16'h0040, 16'h0000, 1'b1, 1'b0, 3, 16'hBEEF, 0);
        run_op("store", 16'h0010, 16'hA5A5, 1'b0, 1'b1, 2, 16'h0000, 0);
        run_op("timeout", 16'h0020, 16'h0000, 1'b1, 1'b0, 99, 16'h1111, 2);
        run_op("backpr", 16'h0080, 16'h0000, 1'b1, 1'b0, 1, 16'hC3C3, 4);
        run_op("illegal", 16'h0BAD, 16'h0000, 1'b1, 1'b1, 1, 16'h0000, 1);
        run_op("edge_lat", 16'h0100, 16'h7777, 1'b0, 1'b1, 15, 16'h0000, 0);
        run_op("odd_load", 16'h0041, 16'h0000, 1'b1, 1'b0, 2, 16'h2468, 0);

        // Reset in the middle of an access, then a late done.
        bus.in_valid = 1'b1;
        bus.alu_res  = 16'h0200;
        bus.mem_rd   = 1'b1;
        bus.mem_wr   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("mid_req", bus.dmem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", bus.dmem_req, 1'b0);
        chk("mid_rst_addr", bus.dmem_addr, 16'h0000);
        chk("mid_rst_valid", bus.wb_valid, 1'b0);
        #1;
        rst_n = 1'b1;
        bus.dmem_done  = 1'b1;
        bus.dmem_rdata = 16'hDEAD;
        tick();
        bus.dmem_done = 1'b0;
        chk("late_done_valid", bus.wb_valid, 1'b0);
        chk("late_done_req", bus.dmem_req, 1'b0);
        chk("late_done_ready", bus.in_ready, 1'b1);

        for (int n = 0; n < 40; n++) begin
            a  = 16'($urandom);
            s  = 16'($urandom);
            rd = 1'($urandom);
            wr = 1'($urandom);
            run_op($sformatf("rnd%0d", n), a, s, rd, wr, int'($urandom_range(1, 18)),
                   16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
